// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchroniser, counter debounce, press/release pulses
// and hold-to-auto-repeat for each of NBTN independent buttons.
module btn_conditioner #(
  parameter int NBTN          = 3,
  parameter int DEB_CYCLES    = 500000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int REPEAT_EN     = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic            clck,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_held
);

  localparam int DW = (DEB_CYCLES    > 1) ? $clog2(DEB_CYCLES)    : 1;
  localparam int HW = (HOLD_CYCLES   > 1) ? $clog2(HOLD_CYCLES)   : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DW-1:0]   DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0]   REP_MAX  = RW'(REPEAT_CYCLES - 1);
  localparam logic            REP_ON   = (REPEAT_EN != 0);
  localparam logic [NBTN-1:0] REL_LVL  = (ACTIVE_LOW != 0) ? {NBTN{1'b1}} : {NBTN{1'b0}};

  typedef enum logic [1:0] {
    REL = 2'd0,
    PRS = 2'd1,
    RPT = 2'd2
  } state_t;

  logic [NBTN-1:0] sync1_r;
  logic [NBTN-1:0] sync2_r;
  logic [NBTN-1:0] p_r;

  // Two-flop synchroniser plus a normalising stage so that p_r reads 1 when pressed.
  always_ff @(posedge clck or posedge reset) begin
    if (reset) begin
      sync1_r <= REL_LVL;
      sync2_r <= REL_LVL;
      p_r     <= {NBTN{1'b0}};
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
      p_r     <= sync2_r ^ REL_LVL;
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    logic [DW-1:0] deb_cnt_r;
    logic [HW-1:0] hold_cnt_r;
    logic [RW-1:0] rep_cnt_r;
    state_t        state_r;
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic          held_r;
    logic          deb_hit_s;
    logic          rise_s;
    logic          fall_s;

    // The FSM reacts on the same edge the debounced level toggles.
    always_comb begin
      deb_hit_s = (p_r[i] != level_r) && (deb_cnt_r == DEB_MAX);
      rise_s    = deb_hit_s && p_r[i];
      fall_s    = deb_hit_s && !p_r[i];
    end

    // Debounce: a level change is accepted only after DEB_CYCLES disagreeing samples.
    always_ff @(posedge clck or posedge reset) begin
      if (reset) begin
        deb_cnt_r <= {DW{1'b0}};
        level_r   <= 1'b0;
      end else if (p_r[i] == level_r) begin
        deb_cnt_r <= {DW{1'b0}};
      end else if (deb_cnt_r == DEB_MAX) begin
        deb_cnt_r <= {DW{1'b0}};
        level_r   <= ~level_r;
      end else begin
        deb_cnt_r <= deb_cnt_r + 1'b1;
      end
    end

    // Press/hold/repeat FSM; a falling level beats any hold or repeat event.
    always_ff @(posedge clck or posedge reset) begin
      if (reset) begin
        state_r    <= REL;
        press_r    <= 1'b0;
        release_r  <= 1'b0;
        held_r     <= 1'b0;
        hold_cnt_r <= {HW{1'b0}};
        rep_cnt_r  <= {RW{1'b0}};
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        case (state_r)
          REL: begin
            if (rise_s) begin
              press_r    <= 1'b1;
              hold_cnt_r <= {HW{1'b0}};
              state_r    <= PRS;
            end
          end
          PRS: begin
            if (fall_s) begin
              release_r  <= 1'b1;
              held_r     <= 1'b0;
              hold_cnt_r <= {HW{1'b0}};
              rep_cnt_r  <= {RW{1'b0}};
              state_r    <= REL;
            end else if (hold_cnt_r == HOLD_MAX) begin
              press_r    <= REP_ON;
              held_r     <= 1'b1;
              hold_cnt_r <= {HW{1'b0}};
              rep_cnt_r  <= {RW{1'b0}};
              state_r    <= RPT;
            end else begin
              hold_cnt_r <= hold_cnt_r + 1'b1;
            end
          end
          RPT: begin
            if (fall_s) begin
              release_r  <= 1'b1;
              held_r     <= 1'b0;
              hold_cnt_r <= {HW{1'b0}};
              rep_cnt_r  <= {RW{1'b0}};
              state_r    <= REL;
            end else if (rep_cnt_r == REP_MAX) begin
              press_r   <= REP_ON;
              rep_cnt_r <= {RW{1'b0}};
            end else begin
              rep_cnt_r <= rep_cnt_r + 1'b1;
            end
          end
          default: begin
            held_r     <= 1'b0;
            hold_cnt_r <= {HW{1'b0}};
            rep_cnt_r  <= {RW{1'b0}};
            state_r    <= REL;
          end
        endcase
      end
    end

    assign btn_level[i]   = level_r;
    assign btn_press[i]   = press_r;
    assign btn_release[i] = release_r;
    assign btn_held[i]    = held_r;
  end

endmodule
